// File: rtl/dram_line_fetcher.sv
// dram_line_fetcher: forwards line-address requests to the memory port while
// limiting how many lines are in flight, then assembles the in-order narrow
// memory beats into full lines returned on the dramrd handshake.
// Optional performance counters are enabled by defining DRAM_LINE_FETCHER_PERF_EN.
module dram_line_fetcher #(
    parameter int GBW     = 32,
    parameter int DBW     = 16,
    parameter int CSIZE   = 32,
    parameter int BEAT_W  = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  dramra_rdy,
    output logic                  dramra_ack,
    input  logic [GBW-1:0]        i_dramra,
    output logic                  memreq_rdy,
    input  logic                  memreq_ack,
    output logic [GBW-1:0]        o_memreq_addr,
    input  logic                  memresp_rdy,
    output logic                  memresp_ack,
    input  logic [DBW*BEAT_W-1:0] i_memresp,
    output logic                  dramrd_rdy,
    input  logic                  dramrd_ack,
    output logic [DBW*CSIZE-1:0]  o_dramrd,
    output logic                  o_busy
`ifdef DRAM_LINE_FETCHER_PERF_EN
    ,
    output logic [31:0]           o_perf_stall,
    output logic [31:0]           o_perf_lines
`endif
);

    localparam int BEATS     = CSIZE / BEAT_W;
    localparam int CW        = $clog2(MAX_OUT + 1);
    localparam int BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = DBW * BEAT_W;

    localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_OUT);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    logic                 req_valid_q, req_valid_d;
    logic [GBW-1:0]       req_addr_q, req_addr_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                 line_valid_q, line_valid_d;
    logic [DBW*CSIZE-1:0] line_q, line_d;

    logic req_accept;
    logic line_done;
    logic beat_take;
    logic last_beat;

    // Handshake acks come straight from local state; a held line blocks further beats.
    always_comb begin
        dramra_ack  = (out_cnt_q < MAX_CNT) && (!req_valid_q || memreq_ack);
        memresp_ack = !line_valid_q || dramrd_ack;
    end

    assign req_accept = dramra_rdy && dramra_ack;
    assign line_done  = line_valid_q && dramrd_ack;
    assign beat_take  = memresp_rdy && memresp_ack;
    assign last_beat  = (beat_cnt_q == LAST_BEAT);

    // One-entry request register: a new request may replace the one being taken by memory.
    always_comb begin
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        if (req_accept) begin
            req_valid_d = 1'b1;
            req_addr_d  = i_dramra;
        end else if (memreq_ack) begin
            req_valid_d = 1'b0;
        end
    end

    // Lines in flight: incremented on request accept, decremented when a line is consumed.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (req_accept && !line_done) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!req_accept && line_done) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
    end

    // Beat assembly: each beat fills its slot of the line; the last beat publishes the line.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        line_valid_d = line_valid_q;
        line_d       = line_q;
        if (line_done) begin
            line_valid_d = 1'b0;
        end
        if (beat_take) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_cnt_q == BCW'(k)) begin
                    line_d[k*BEAT_BITS +: BEAT_BITS] = i_memresp;
                end
            end
            if (last_beat) begin
                beat_cnt_d   = '0;
                line_valid_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end
    end

    // State registers with synchronous reset; reset discards any partial transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            out_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            line_valid_q <= 1'b0;
            line_q       <= '0;
        end else begin
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            out_cnt_q    <= out_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            line_valid_q <= line_valid_d;
            line_q       <= line_d;
        end
    end

    assign memreq_rdy    = req_valid_q;
    assign o_memreq_addr = req_addr_q;
    assign dramrd_rdy    = line_valid_q;
    assign o_dramrd      = line_q;
    assign o_busy        = (out_cnt_q != '0) || req_valid_q;

`ifdef DRAM_LINE_FETCHER_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_lines_q, perf_lines_d;

    // Saturating counters for memory-side stall cycles and returned lines.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_lines_d = perf_lines_q;
        if (memresp_rdy && !memresp_ack && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (line_done && (perf_lines_q != '1)) begin
            perf_lines_d = perf_lines_q + 32'd1;
        end
    end

    // Performance counter registers, cleared with the rest of the block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_stall_q <= '0;
            perf_lines_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_lines_q <= perf_lines_d;
        end
    end

    assign o_perf_stall = perf_stall_q;
    assign o_perf_lines = perf_lines_q;
`endif

    // A beat with no line in flight means memory broke request/response pairing.
    beat_without_request: assert property (@(posedge i_clk) disable iff (i_rst)
        (memresp_rdy && memresp_ack) |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_dram_line_fetcher.sv
// Testbench for dram_line_fetcher: randomized memory/consumer behaviour, an
// expected-line scoreboard fed at request time, and directed boundary checks.
`timescale 1ns/1ps
module tb_dram_line_fetcher;

    localparam int GBW     = 32;
    localparam int DBW     = 16;
    localparam int CSIZE   = 32;
    localparam int BEAT_W  = 8;
    localparam int MAX_OUT = 4;
    localparam int BEATS   = CSIZE / BEAT_W;
    localparam int LW      = DBW * CSIZE;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  dramra_rdy;
    logic                  dramra_ack;
    logic [GBW-1:0]        i_dramra;
    logic                  memreq_rdy;
    logic                  memreq_ack;
    logic [GBW-1:0]        o_memreq_addr;
    logic                  memresp_rdy;
    logic                  memresp_ack;
    logic [DBW*BEAT_W-1:0] i_memresp;
    logic                  dramrd_rdy;
    logic                  dramrd_ack;
    logic [LW-1:0]         o_dramrd;
    logic                  o_busy;
`ifdef DRAM_LINE_FETCHER_PERF_EN
    logic [31:0]           o_perf_stall;
    logic [31:0]           o_perf_lines;
`endif

    dram_line_fetcher #(
        .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .BEAT_W(BEAT_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .dramra_rdy(dramra_rdy),
        .dramra_ack(dramra_ack),
        .i_dramra(i_dramra),
        .memreq_rdy(memreq_rdy),
        .memreq_ack(memreq_ack),
        .o_memreq_addr(o_memreq_addr),
        .memresp_rdy(memresp_rdy),
        .memresp_ack(memresp_ack),
        .i_memresp(i_memresp),
        .dramrd_rdy(dramrd_rdy),
        .dramrd_ack(dramrd_ack),
        .o_dramrd(o_dramrd),
        .o_busy(o_busy)
`ifdef DRAM_LINE_FETCHER_PERF_EN
        ,
        .o_perf_stall(o_perf_stall),
        .o_perf_lines(o_perf_lines)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int memreq_mode = 1;
    int cons_mode = 1;
    bit mem_en = 1'b1;

    logic [GBW-1:0] exp_q[$];
    logic [GBW-1:0] mem_q[$];
    int beat_idx = 0;
    int beats_taken = 0;
    int stall_cnt = 0;
    int lines_cnt = 0;
    int last_ret_cyc = 0;
    int last_acc_cyc = 0;
    int last_beat_cyc = 0;

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // Cycle index used to measure handshake latencies.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory contents: address 0x1000 holds words 0..CSIZE-1, others a per-address pattern.
    function automatic logic [DBW-1:0] ref_word(input logic [GBW-1:0] a, input int i);
        logic [31:0] mix;
        mix = (a - 32'h1000) * 32'h9E37;
        return DBW'(i) ^ mix[DBW-1:0];
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [GBW-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < CSIZE; i++) l[i*DBW +: DBW] = ref_word(a, i);
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                               input logic [LW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input int actual, input int expected);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Memory model: accepts requests, returns BEATS beats per line in request order.
    initial begin
        bit beat_accepted;
        beat_accepted = 1'b0;
        memreq_ack  = 1'b0;
        memresp_rdy = 1'b0;
        i_memresp   = '0;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_rst) begin
                memreq_ack    = 1'b0;
                memresp_rdy   = 1'b0;
                beat_accepted = 1'b0;
                beat_idx      = 0;
                mem_q.delete();
            end else begin
                memreq_ack = (memreq_mode == 1) ? 1'b1 :
                             (memreq_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (beat_accepted) begin
                    memresp_rdy   = 1'b0;
                    beat_accepted = 1'b0;
                end
                if (!memresp_rdy && mem_en && (mem_q.size() > 0) && ($urandom_range(0, 3) != 0)) begin
                    memresp_rdy = 1'b1;
                    for (int w = 0; w < BEAT_W; w++)
                        i_memresp[w*DBW +: DBW] = ref_word(mem_q[0], beat_idx*BEAT_W + w);
                end
                #1;
                if (memreq_rdy && memreq_ack) mem_q.push_back(o_memreq_addr);
                if (memresp_rdy && !memresp_ack) stall_cnt++;
                if (memresp_rdy && memresp_ack) begin
                    beat_accepted = 1'b1;
                    beats_taken++;
                    beat_idx++;
                    if (beat_idx == BEATS) begin
                        beat_idx = 0;
                        last_beat_cyc = cyc;
                        void'(mem_q.pop_front());
                    end
                end
            end
        end
    end

    // Consumer and scoreboard monitor: compares each returned line against the expected queue.
    initial begin
        bit prev_rdy;
        logic [GBW-1:0] a;
        prev_rdy   = 1'b0;
        dramrd_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_rst) dramrd_ack = 1'b0;
            else if (cons_mode == 0) dramrd_ack = 1'b0;
            else if (cons_mode == 1) dramrd_ack = ($urandom_range(0, 2) != 0);
            else dramrd_ack = 1'b1;
            #1;
            if (!i_rst) begin
                if (dramrd_rdy && !prev_rdy)
                    checkOutput("line_latency", LW'(cyc - last_beat_cyc), LW'(1));
                if (dramrd_rdy && dramrd_ack) begin
                    if (exp_q.size() == 0) begin
                        failNow("unexpected_line", 1, 0);
                    end else begin
                        a = exp_q.pop_front();
                        checkOutput("line_data", o_dramrd, ref_line(a));
                    end
                    lines_cnt++;
                    last_ret_cyc = cyc;
                end
            end
            prev_rdy = dramrd_rdy;
        end
    end

    // Offer one request (called at a falling edge); expected line is queued on accept.
    task automatic applyStimulus(input logic [GBW-1:0] a, input int budget, output bit ok);
        dramra_rdy = 1'b1;
        i_dramra   = a;
        ok         = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            #2;
            if (dramra_ack) begin
                ok = 1'b1;
                last_acc_cyc = cyc;
                exp_q.push_back(a);
            end
            @(negedge i_clk);
        end
        dramra_rdy = 1'b0;
    endtask

    task automatic doReset(input int n);
        i_rst      = 1'b1;
        dramra_rdy = 1'b0;
        exp_q.delete();
        stall_cnt  = 0;
        lines_cnt  = 0;
        repeat (n) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic checkReset();
        #2;
        checkOutput("rst_memreq_rdy", LW'(memreq_rdy), LW'(0));
        checkOutput("rst_dramrd_rdy", LW'(dramrd_rdy), LW'(0));
        checkOutput("rst_busy", LW'(o_busy), LW'(0));
        checkOutput("rst_memreq_addr", LW'(o_memreq_addr), LW'(0));
        checkOutput("rst_dramrd", o_dramrd, LW'(0));
        checkOutput("rst_dramra_ack", LW'(dramra_ack), LW'(1));
        @(negedge i_clk);
    endtask

    task automatic waitDrain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0) && (c < budget)) begin
            @(negedge i_clk);
            c++;
        end
        if (exp_q.size() != 0) failNow("drain_timeout", exp_q.size(), 0);
        #2;
        checkOutput("idle_busy", LW'(o_busy), LW'(0));
        @(negedge i_clk);
    endtask

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        bit ok;
        int accepted;
        int c;
        int base;
        logic [LW-1:0] snap;

        i_rst      = 1'b1;
        dramra_rdy = 1'b0;
        i_dramra   = '0;
        @(negedge i_clk);
        doReset(2);
        checkReset();

        $display("[TB] single request");
        memreq_mode = 1; cons_mode = 1; mem_en = 1'b1;
        applyStimulus(32'h1000, 5, ok);
        checkOutput("single_accept", LW'(ok), LW'(1));
        #2;
        checkOutput("single_memreq_rdy", LW'(memreq_rdy), LW'(1));
        checkOutput("single_memreq_addr", LW'(o_memreq_addr), LW'(32'h1000));
        @(negedge i_clk);
        waitDrain(200);

        $display("[TB] outstanding limit");
        mem_en = 1'b0; cons_mode = 0; memreq_mode = 1;
        accepted = 0;
        for (int i = 0; i < MAX_OUT; i++) begin
            applyStimulus(32'h2000 + 32'(i) * 32'h40, 1, ok);
            accepted += int'(ok);
        end
        checkOutput("back_to_back_accepts", LW'(accepted), LW'(MAX_OUT));
        dramra_rdy = 1'b1;
        i_dramra   = 32'h2100;
        repeat (3) begin
            #2;
            checkOutput("limit_ack_low", LW'(dramra_ack), LW'(0));
            checkOutput("limit_busy", LW'(o_busy), LW'(1));
            @(negedge i_clk);
        end
        mem_en = 1'b1; cons_mode = 1;
        applyStimulus(32'h2100, 400, ok);
        checkOutput("limit_fifth_accept", LW'(ok), LW'(1));
        checkOutput("limit_release_latency", LW'(last_acc_cyc - last_ret_cyc), LW'(1));
        applyStimulus(32'h2140, 400, ok);
        checkOutput("limit_sixth_accept", LW'(ok), LW'(1));
        waitDrain(400);

        $display("[TB] consumer back-pressure");
        cons_mode = 0; mem_en = 1'b1; memreq_mode = 0;
        applyStimulus(32'h3000, 20, ok);
        applyStimulus(32'h3040, 20, ok);
        c = 0;
        while (c < 200) begin
            #2;
            if (dramrd_rdy && memresp_rdy) break;
            @(negedge i_clk);
            c++;
        end
        if (c == 200) failNow("bp_timeout", c, 0);
        snap = o_dramrd;
        repeat (4) begin
            @(negedge i_clk);
            #2;
            checkOutput("bp_memresp_ack", LW'(memresp_ack), LW'(0));
            checkOutput("bp_line_held", LW'(dramrd_rdy), LW'(1));
            checkOutput("bp_line_stable", o_dramrd, snap);
        end
        @(negedge i_clk);
        cons_mode = 2;
        #2;
        checkOutput("bp_release_same_cycle", LW'(memresp_ack && memresp_rdy), LW'(1));
        @(negedge i_clk);
        cons_mode = 1;
        waitDrain(400);

        $display("[TB] memory request stall");
        memreq_mode = 2; cons_mode = 1; mem_en = 1'b1;
        applyStimulus(32'h4000, 5, ok);
        checkOutput("stall_first_accept", LW'(ok), LW'(1));
        dramra_rdy = 1'b1;
        i_dramra   = 32'h5000;
        repeat (3) begin
            #2;
            checkOutput("stall_ack_low", LW'(dramra_ack), LW'(0));
            checkOutput("stall_addr_stable", LW'(o_memreq_addr), LW'(32'h4000));
            @(negedge i_clk);
        end
        memreq_mode = 1;
        applyStimulus(32'h5000, 1, ok);
        checkOutput("stall_same_cycle_load", LW'(ok), LW'(1));
        #2;
        checkOutput("stall_new_addr", LW'(o_memreq_addr), LW'(32'h5000));
        @(negedge i_clk);
        waitDrain(400);

        $display("[TB] reset mid-line");
        memreq_mode = 1; cons_mode = 1; mem_en = 1'b1;
        base = beats_taken;
        applyStimulus(32'h6000, 5, ok);
        c = 0;
        while (c < 200) begin
            @(negedge i_clk);
            #3;
            if (beats_taken >= base + 2) break;
            c++;
        end
        if (c == 200) failNow("midrst_timeout", beats_taken - base, 2);
        @(negedge i_clk);
        doReset(2);
        checkReset();
        applyStimulus(32'h7000, 5, ok);
        checkOutput("midrst_fresh_accept", LW'(ok), LW'(1));
        waitDrain(400);

        $display("[TB] randomized traffic");
        memreq_mode = 0; cons_mode = 1; mem_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            applyStimulus($urandom, 400, ok);
            checkOutput("random_accept", LW'(ok), LW'(1));
        end
        waitDrain(3000);

`ifdef DRAM_LINE_FETCHER_PERF_EN
        #2;
        checkOutput("perf_stall", LW'(o_perf_stall), LW'(stall_cnt));
        checkOutput("perf_lines", LW'(o_perf_lines), LW'(lines_cnt));
        @(negedge i_clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_line_fetcher.md
Name: dram_line_fetcher

Overview:
- Sits between the read pipeline's DRAM address/data handshakes (dramra out, dramrd in) and the external memory port.
- Accepts line-address requests, forwards them to memory with a bounded number of outstanding lines, and assembles narrow in-order memory beats into CSIZE-word lines.
- Returns each assembled line on the dramrd handshake.

Parameters:
GBW, 32, global address width (TauCfg::GLOBAL_ADDR_BW)
DBW, 16, data word width (TauCfg::DATA_BW)
CSIZE, 32, words per line (TauCfg::CACHE_SIZE)
BEAT_W, 8, words per memory beat; CSIZE must be a multiple of BEAT_W; BEATS = CSIZE/BEAT_W
MAX_OUT, 4, maximum outstanding lines (requested, not yet returned on dramrd)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
dramra_rdy  in  1  line request valid
dramra_ack  out  1  line request accepted
i_dramra  in  GBW  line address
memreq_rdy  out  1  memory request valid
memreq_ack  in  1  memory accepted request
o_memreq_addr  out  GBW  memory request address
memresp_rdy  in  1  memory beat valid
memresp_ack  out  1  beat accepted
i_memresp  in  DBW x BEAT_W  beat data, word 0 first
dramrd_rdy  out  1  assembled line valid
dramrd_ack  in  1  line consumed
o_dramrd  out  DBW x CSIZE  assembled line
o_busy  out  1  outstanding count non-zero or request register full

Behaviour:
- Handshake rule: a transfer occurs on a cycle with rdy && ack. A rdy, once raised, holds with stable data until acked. An ack is asserted only combinationally from local state, never from the peer's ack.
- Reset (i_rst high at a clock edge):
  - memreq_rdy=0, dramrd_rdy=0, o_busy=0; outstanding count=0; beat count=0; o_memreq_addr=0; o_dramrd=0.
  - Reset mid-transfer discards all state.
- Request path:
  - One-entry request register.
  - dramra_ack = (outstanding < MAX_OUT) && (!memreq_rdy || memreq_ack). Back-to-back throughput is one request per cycle.
  - On accept, the register loads i_dramra unmodified and memreq_rdy rises the next cycle (1-cycle latency).
  - The register clears on memreq_ack unless a new request loads in the same cycle.
- Outstanding counter:
  - Counts accepted dramra requests minus completed dramrd acks; width clog2(MAX_OUT+1).
  - A simultaneous increment and decrement leaves the count unchanged.
  - The counter never exceeds MAX_OUT; dramra_ack is held low at MAX_OUT.
- Response assembly:
  - Beat counter runs 0..BEATS-1. Beat k writes o_dramrd words k*BEAT_W .. k*BEAT_W+BEAT_W-1.
  - memresp_ack = !dramrd_rdy || dramrd_ack, so a beat may land in the same cycle the held line is consumed.
  - On the last beat (count BEATS-1) the counter wraps to 0 and dramrd_rdy rises the next cycle.
  - While a line is held and not acked, memresp_ack=0 and stall back-pressure reaches memory.
- Simultaneous events:
  - If dramrd_ack and an accepted beat 0 coincide, the old line is returned and beat 0 of the next line is written; the unwritten words of o_dramrd keep stale data until overwritten.
  - dramrd_rdy falls unless that beat is also the last beat (BEATS=1 case), in which case it stays high.
- Memory returns beats strictly in request order. A beat arriving while the outstanding count is 0 is a protocol error and is flagged by a simulation assertion only.
- o_busy = (outstanding != 0) || memreq_rdy.

Optional Feature:
- Macro DRAM_LINE_FETCHER_PERF_EN.
- When defined, adds output o_perf_stall [31:0] and o_perf_lines [31:0], both cleared by i_rst and saturating at all-ones:
  - o_perf_stall counts cycles with memresp_rdy && !memresp_ack.
  - o_perf_lines counts dramrd acks.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single request 0x1000, memreq_ack same cycle; memory returns 4 beats of words 0..31 → o_memreq_addr=0x1000 one cycle after accept; dramrd_rdy one cycle after the 4th beat; o_dramrd[i]=i; o_busy=0 after dramrd_ack.
- 6 back-to-back requests, memory holds responses → exactly 4 accepted, dramra_ack=0 on the 5th; after one line is acked, the 5th is accepted within 1 cycle.
- dramrd_ack held low after a line completes while memory offers beats → memresp_ack=0 throughout; the line stays stable; ack then releases beat 0 in the same cycle.
- memreq_ack held low 3 cycles with a pending dramra → dramra_ack=0, o_memreq_addr stable; when memreq_ack=1, the new request loads in that same cycle.
- Assert i_rst after 2 of 4 beats → all outputs 0 next cycle; the next 4 beats form a fresh complete line.
- With DRAM_LINE_FETCHER_PERF_EN: 5 stalled beat cycles and 2 lines → o_perf_stall=5, o_perf_lines=2.
